// File: rtl/hazard_ctrl.sv
// Stall/flush control for the five-stage pipe plus I/D main-memory arbiter and stall counter.
// Controls are combinational and take effect at once; grants follow a request by one edge; D-cache wins ties.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fd_valid,
    input  logic [3:0]       fd_regRs,
    input  logic [3:0]       fd_regRt,
    input  logic             fd_useRt,
    input  logic             de_memread,
    input  logic [3:0]       de_dstreg,
    input  logic             branch_taken,
    input  logic             icache_req,
    input  logic             icache_done,
    input  logic             dcache_req,
    input  logic             dcache_done,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             mem_grant_i,
    output logic             mem_grant_d,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERV_D = 2'd1,
        SERV_I = 2'd2
    } arbState_t;

    arbState_t state;

    logic freeze;
    logic luse;
    logic istall;
    logic srcMatch;

    assign freeze   = dcache_req & ~dcache_done;
    assign istall   = icache_req & ~icache_done;
    assign srcMatch = (de_dstreg == fd_regRs) | (fd_useRt & (de_dstreg == fd_regRt));
    assign luse     = de_memread & (de_dstreg != 4'd0) & fd_valid & srcMatch;

    // Priority: freeze > load-use > branch > I-miss. A taken branch redirects the PC even mid-fill.
    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        de_en    = 1'b1;
        em_en    = 1'b1;
        mw_en    = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        if (!rst_n) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            de_en = 1'b0;
            em_en = 1'b0;
            mw_en = 1'b0;
        end else if (freeze) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            de_en = 1'b0;
            em_en = 1'b0;
            mw_en = 1'b0;
        end else if (luse) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
        end else if (branch_taken) begin
            fd_flush = 1'b1;
        end else if (istall) begin
            pc_en    = 1'b0;
            fd_flush = 1'b1;
        end
    end

    // Grants are registered alongside the state so they can never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_grant_d <= 1'b0;
            mem_grant_i <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dcache_req) begin
                        state       <= SERV_D;
                        mem_grant_d <= 1'b1;
                        mem_grant_i <= 1'b0;
                    end else if (icache_req) begin
                        state       <= SERV_I;
                        mem_grant_d <= 1'b0;
                        mem_grant_i <= 1'b1;
                    end
                end
                SERV_D: begin
                    if (dcache_done) begin
                        if (icache_req) begin
                            state       <= SERV_I;
                            mem_grant_d <= 1'b0;
                            mem_grant_i <= 1'b1;
                        end else begin
                            state       <= IDLE;
                            mem_grant_d <= 1'b0;
                            mem_grant_i <= 1'b0;
                        end
                    end
                end
                SERV_I: begin
                    if (icache_done) begin
                        if (dcache_req) begin
                            state       <= SERV_D;
                            mem_grant_d <= 1'b1;
                            mem_grant_i <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            mem_grant_d <= 1'b0;
                            mem_grant_i <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem_grant_d <= 1'b0;
                    mem_grant_i <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a behavioural model pushes expected controls/grants/count each cycle.
module tb_hazard_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          fd_valid;
    logic [3:0]    fd_regRs;
    logic [3:0]    fd_regRt;
    logic          fd_useRt;
    logic          de_memread;
    logic [3:0]    de_dstreg;
    logic          branch_taken;
    logic          icache_req;
    logic          icache_done;
    logic          dcache_req;
    logic          dcache_done;
    logic          pc_en, fd_en, de_en, em_en, mw_en;
    logic          fd_flush, de_flush;
    logic          mem_grant_i, mem_grant_d;
    logic [CW-1:0] stall_cycles;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fd_valid     (fd_valid),
        .fd_regRs     (fd_regRs),
        .fd_regRt     (fd_regRt),
        .fd_useRt     (fd_useRt),
        .de_memread   (de_memread),
        .de_dstreg    (de_dstreg),
        .branch_taken (branch_taken),
        .icache_req   (icache_req),
        .icache_done  (icache_done),
        .dcache_req   (dcache_req),
        .dcache_done  (dcache_done),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .de_en        (de_en),
        .em_en        (em_en),
        .mw_en        (mw_en),
        .fd_flush     (fd_flush),
        .de_flush     (de_flush),
        .mem_grant_i  (mem_grant_i),
        .mem_grant_d  (mem_grant_d),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]    ctl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sbQueue[$];
    int            nChecks = 0;
    int            nFail   = 0;
    int            mState  = 0;  // 0 idle, 1 serving D, 2 serving I
    logic [CW-1:0] mCnt    = '0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // {pc, fd, de, em, mw, fd_flush, de_flush} straight from the priority rules
    function automatic logic [6:0] modelCtl();
        logic fz, lu, is;
        fz = dcache_req & ~dcache_done;
        is = icache_req & ~icache_done;
        lu = de_memread && de_dstreg != 0 && fd_valid &&
             (de_dstreg == fd_regRs || (fd_useRt && de_dstreg == fd_regRt));
        if (!rst_n)            return 7'b00000_00;
        else if (fz)           return 7'b00000_00;
        else if (lu)           return 7'b00111_01;
        else if (branch_taken) return 7'b11111_10;
        else if (is)           return 7'b01111_10;
        else                   return 7'b11111_00;
    endfunction

    function automatic logic [8:0] dutVec();
        return {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, mem_grant_i, mem_grant_d};
    endfunction

    task automatic step(input string tag);
        exp_t e;
        logic [6:0] c;
        c     = modelCtl();
        e.ctl = {c, mState == 2, mState == 1};
        e.cnt = mCnt;
        sbQueue.push_back(e);
        @(negedge clk);
        e = sbQueue.pop_front();
        checkVal({tag, ".ctl"}, 32'(dutVec()), 32'(e.ctl));
        checkVal({tag, ".cnt"}, 32'(stall_cycles), 32'(e.cnt));
        @(posedge clk);
        if (!c[6] && mCnt != {CW{1'b1}}) mCnt = mCnt + 1'b1;
        case (mState)
            0: if (dcache_req) mState = 1; else if (icache_req) mState = 2;
            1: if (dcache_done) mState = icache_req ? 2 : 0;
            2: if (icache_done) mState = dcache_req ? 1 : 0;
            default: mState = 0;
        endcase
        #1;
    endtask

    task automatic clearHazard();
        de_memread   = 1'b0;
        de_dstreg    = 4'd0;
        fd_regRs     = 4'd0;
        fd_regRt     = 4'd0;
        fd_useRt     = 1'b0;
        fd_valid     = 1'b1;
        branch_taken = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        icache_req  = 1'b0;
        icache_done = 1'b0;
        dcache_req  = 1'b0;
        dcache_done = 1'b0;
        clearHazard();
        #2;
        checkVal("reset.ctl", 32'(dutVec()), 32'h0);
        checkVal("reset.cnt", 32'(stall_cycles), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step("idle");

        de_memread = 1'b1; de_dstreg = 4'd3; fd_regRs = 4'd3;
        step("luse_rs");
        clearHazard();
        step("luse_after");
        checkVal("luse_count", 32'(stall_cycles), 32'd1);

        de_memread = 1'b1; de_dstreg = 4'd0; fd_regRs = 4'd0;
        step("r0_dst");
        de_dstreg = 4'd5; fd_regRs = 4'd1; fd_regRt = 4'd5; fd_useRt = 1'b1;
        step("luse_rt");
        fd_useRt = 1'b0;
        step("rt_unused");
        fd_useRt = 1'b1; fd_valid = 1'b0;
        step("fd_bubble");
        clearHazard();
        branch_taken = 1'b1;
        step("branch_only");
        clearHazard();

        // D-miss of 10 cycles; a load-use and a branch are hidden under the freeze mid-way
        dcache_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            dcache_done = (c == 10);
            if (c == 5) begin
                de_memread = 1'b1; de_dstreg = 4'd2; fd_regRs = 4'd2; branch_taken = 1'b1;
            end else begin
                clearHazard();
            end
            step($sformatf("dmiss%0d", c));
        end
        dcache_req = 1'b0; dcache_done = 1'b0;
        step("dmiss_end");

        // Simultaneous misses: D served first, then I with no idle gap
        dcache_req = 1'b1; icache_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            dcache_done = (c == 4);
            step($sformatf("both%0d", c));
        end
        dcache_req = 1'b0; dcache_done = 1'b0;
        step("serv_i");
        checkVal("handoff_gi", 32'(mem_grant_i), 32'd1);
        branch_taken = 1'b1;
        step("branch_istall");
        de_memread = 1'b1; de_dstreg = 4'd7; fd_regRs = 4'd7;
        step("branch_luse_istall");
        clearHazard();
        icache_done = 1'b1;
        step("idone");
        icache_req = 1'b0; icache_done = 1'b0;
        step("i_end");
        step("idle2");

        icache_req = 1'b1;
        for (int c = 1; c <= 20; c++) step($sformatf("sat%0d", c));
        checkVal("saturated", 32'(stall_cycles), 32'd15);
        checkVal("sat_grant_i", 32'(mem_grant_i), 32'd1);

        // Asynchronous reset mid-service
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("arst.ctl", 32'(dutVec()), 32'h0);
        checkVal("arst.cnt", 32'(stall_cycles), 32'h0);
        mState = 0; mCnt = '0;
        icache_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_reset");
        step("post_reset2");

        if (sbQueue.size() != 0) checkVal("sb_empty", 32'(sbQueue.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall/flush controller and shared main-memory arbiter for the five-stage core. It combines load-use hazard detection, taken-branch flush and cache-miss freezes into per-latch enable and flush controls. It arbitrates the single main-memory port between the I-cache and the D-cache, and keeps a saturating stall-cycle counter. It sits beside the forwarding logic and handles every hazard that forwarding cannot resolve.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- fd_valid  in  1  F/D latch holds a real instruction (not a bubble)
- fd_regRs  in  4  Rs field of the instruction in F/D
- fd_regRt  in  4  Rt field of the instruction in F/D
- fd_useRt  in  1  F/D instruction reads Rt
- de_memread  in  1  D/E instruction is a load
- de_dstreg  in  4  destination register of the D/E instruction
- branch_taken  in  1  branch resolved taken in decode this cycle
- icache_req  in  1  I-cache miss; held high until the cycle after icache_done
- icache_done  in  1  one-cycle pulse: I-cache fill complete, fetch data valid this cycle
- dcache_req  in  1  D-cache miss; held high until the cycle after dcache_done
- dcache_done  in  1  one-cycle pulse: D-cache fill complete, data valid this cycle
- pc_en, fd_en, de_en, em_en, mw_en  out  1 each  write enables for the PC and the pipeline latches
- fd_flush  out  1  load a NOP into F/D at the next edge
- de_flush  out  1  load a bubble into D/E at the next edge
- mem_grant_i  out  1  main-memory port owned by the I-cache (registered)
- mem_grant_d  out  1  main-memory port owned by the D-cache (registered)
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0

## Operation
Derived terms:
- freeze = dcache_req & ~dcache_done
- luse = de_memread & (de_dstreg != 0) & fd_valid & (de_dstreg == fd_regRs | (fd_useRt & de_dstreg == fd_regRt))
- istall = icache_req & ~icache_done

Control priority is freeze > luse > branch > istall:
- **freeze:** all five enables are 0; both flushes are 0.
- **luse:** pc_en=0, fd_en=0, de_flush=1; de_en, em_en and mw_en are 1.
- **branch_taken** (only when there is no freeze and no luse): pc_en=1 (redirect), fd_flush=1, all other enables 1. The branch redirect overrides istall; the wrong-path fill still completes normally.
- **istall** alone: pc_en=0, fd_flush=1; fd_en through mw_en are 1.
- **Otherwise:** all enables 1 and both flushes 0.
- branch_taken is ignored while freeze or luse is active.

Arbiter FSM (states IDLE, SERV_D, SERV_I):
- From IDLE: dcache_req goes to SERV_D; otherwise icache_req goes to SERV_I; otherwise stay in IDLE. The D-cache has fixed priority.
- In SERV_D: on dcache_done, go to SERV_I if icache_req=1, else IDLE. SERV_I mirrors this (on icache_done, go to SERV_D if dcache_req=1, else IDLE).
- mem_grant_d = (state==SERV_D) and mem_grant_i = (state==SERV_I). Both are decoded from the state register, so they are never high together.
- A done pulse from the requester that does not hold the grant is ignored. Its stall terms still deassert by the equations above; the cache must not pulse done without the grant.

Counter:
- stall_cycles increments on each edge where pc_en=0.
- It saturates at 2^CNT_W-1 and never wraps.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, both grants 0, stall_cycles=0. All enables and flushes are forced to 0 while rst_n=0.
- Enable and flush outputs are combinational from the current-cycle inputs, with zero latency.
- Request to grant: one cycle. A request seen in IDLE at edge N gives the grant from edge N. A back-to-back handoff happens at the same edge as the done pulse, with no idle cycle between owners.
- Reset asserted mid-service drops the grant immediately. The cache is responsible for abandoning its fill.
- A load-use stall lasts exactly one cycle. On the next cycle the bubble occupies D/E, so luse=0.
- freeze is released on the dcache_done cycle: all enables are 1 on that edge.

## Test plan
- **Load-use hazard:** de_memread=1, de_dstreg=3, fd_regRs=3, fd_valid=1 -> pc_en=fd_en=0, de_flush=1 for one cycle; stall_cycles increments by 1.
- **R0 destination:** as above but de_dstreg=0 -> no stall, all enables 1.
- **D-cache miss:** dcache_req high for 10 cycles with done on cycle 10 -> mem_grant_d high one cycle after the request; all enables 0 for 9 cycles, then 1; grant drops after done.
- **Simultaneous misses:** icache_req and dcache_req rise together -> SERV_D first; on dcache_done, mem_grant_i is set the same edge with no IDLE gap.
- **Branch during I-miss:** branch_taken=1 while istall=1 -> pc_en=1, fd_flush=1. With luse also active -> branch ignored, luse controls apply.
- **Counter and reset:** with CNT_W=4, hold istall for 20 cycles -> stall_cycles saturates at 15. Pulse rst_n low mid-SERV_I -> grant 0 and counter 0 asynchronously.
